// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants for the timing source and every pixel generator.
// Window comparisons go through in_window() so all consumers agree on edge inclusivity.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_H_VIS   = 640;
    localparam int VGA_H_FP    = 16;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BP    = 48;
    localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_VIS   = 480;
    localparam int VGA_V_FP    = 10;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BP    = 33;
    localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Both syncs are active-low for this mode.
    localparam logic SYNC_ACTIVE = 1'b0;
    localparam logic SYNC_IDLE   = 1'b1;

    // Half-open window test: lo <= c < hi.
    function automatic logic in_window(input logic [COORD_W-1:0] c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

endpackage

// File: rtl/vga_pix_strobe.sv
// Pixel-rate divider: free-running 0..PIX_DIV-1 counter, strobe on the last count.
// With PIX_DIV=1 the counter is pinned at zero and the strobe is high every cycle.
module vga_pix_strobe #(
    parameter int PIX_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic strobe
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div;

    assign strobe = (div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (strobe) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: h/v counters, syncs, visible flag, frame and animation ticks.
// Every output is registered from the counters' next values so all of them change together.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIX_DIV     = 4,
    parameter int H_VIS       = VGA_H_VIS,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_VIS       = VGA_V_VIS,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter int ANIM_FRAMES = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [COORD_W-1:0] h_cnt,
    output logic [COORD_W-1:0] v_cnt,
    output logic               valid,
    output logic               hsync,
    output logic               vsync,
    output logic               pix_en,
    output logic               frame_tick,
    output logic               anim_tick
);

    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_BLANK   = COORD_W'(V_VIS);
    localparam logic [7:0]         ANIM_LAST = 8'(ANIM_FRAMES - 1);

    logic               strobe;
    logic [COORD_W-1:0] h_nxt;
    logic [COORD_W-1:0] v_nxt;
    logic               frame_nxt;
    logic               anim_nxt;
    logic [7:0]         acnt;

    vga_pix_strobe #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_strobe (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (strobe)
    );

    always_comb begin
        h_nxt = h_cnt + 1'b1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
    end

    // Frame tick marks entry into vertical blanking, not the top of the frame.
    assign frame_nxt = strobe && (h_nxt == '0) && (v_nxt == V_BLANK);
    assign anim_nxt  = frame_nxt && (acnt == ANIM_LAST);

    // Reset parks the counters on the last pixel so the first strobe lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= H_LAST;
            v_cnt <= V_LAST;
            hsync <= SYNC_IDLE;
            vsync <= SYNC_IDLE;
            valid <= 1'b0;
        end else if (strobe) begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            hsync <= in_window(h_nxt, HS_START, HS_END) ? SYNC_ACTIVE : SYNC_IDLE;
            vsync <= in_window(v_nxt, VS_START, VS_END) ? SYNC_ACTIVE : SYNC_IDLE;
            valid <= in_window(h_nxt, 0, H_VIS) && in_window(v_nxt, 0, V_VIS);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_en     <= 1'b0;
            frame_tick <= 1'b0;
            anim_tick  <= 1'b0;
        end else begin
            pix_en     <= strobe;
            frame_tick <= frame_nxt;
            anim_tick  <= anim_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acnt <= '0;
        end else if (frame_nxt) begin
            acnt <= anim_nxt ? '0 : acnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default geometry for line timing, a shrunken geometry for
// multi-frame scoreboard checks, and a PIX_DIV=1 build for the full-rate strobe.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v;
    logic a_valid, a_hs, a_vs, a_pe, a_ft, a_at;
    logic b_valid, b_hs, b_vs, b_pe, b_ft, b_at;
    logic c_valid, c_hs, c_vs, c_pe, c_ft, c_at;

    vga_timing_gen u_dut_a (
        .clk(clk), .rst_n(rst_a), .h_cnt(a_h), .v_cnt(a_v), .valid(a_valid),
        .hsync(a_hs), .vsync(a_vs), .pix_en(a_pe), .frame_tick(a_ft), .anim_tick(a_at)
    );

    // Small raster: H 16+2+4+2=24, V 8+2+2+2=14, frame = 24*14*4 = 1344 clk.
    vga_timing_gen #(
        .PIX_DIV(4), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(2), .ANIM_FRAMES(6)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_b), .h_cnt(b_h), .v_cnt(b_v), .valid(b_valid),
        .hsync(b_hs), .vsync(b_vs), .pix_en(b_pe), .frame_tick(b_ft), .anim_tick(b_at)
    );

    vga_timing_gen #(.PIX_DIV(1)) u_dut_c (
        .clk(clk), .rst_n(rst_c), .h_cnt(c_h), .v_cnt(c_v), .valid(c_valid),
        .hsync(c_hs), .vsync(c_vs), .pix_en(c_pe), .frame_tick(c_ft), .anim_tick(c_at)
    );

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       valid;
        logic       hs;
        logic       vs;
        logic       ft;
        logic       at;
    } pix_t;

    pix_t sb_q[$];
    bit   sb_en, space_en, vs_en;
    int   errors, checks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected pixel stream for the small raster, hand-derived window edges.
    task automatic push_frames(input int n);
        int   ticks;
        pix_t e;
        ticks = 0;
        for (int f = 0; f < n; f++)
            for (int v = 0; v < 14; v++)
                for (int h = 0; h < 24; h++) begin
                    e.h     = 10'(h);
                    e.v     = 10'(v);
                    e.valid = (h < 16) && (v < 8);
                    e.hs    = !((h >= 18) && (h < 22));
                    e.vs    = !((v >= 10) && (v < 12));
                    e.ft    = (h == 0) && (v == 8);
                    if (e.ft) ticks++;
                    e.at    = e.ft && (ticks % 6 == 0);
                    sb_q.push_back(e);
                end
    endtask

    task automatic sb_monitor();
        pix_t got, exp;
        int   last_pe;
        last_pe = -1;
        forever begin
            @(negedge clk);
            if (!sb_en) begin
                last_pe = -1;
            end else begin
                if (b_ft || b_at) check("tick_on_pix_en", b_pe, 1);
                if (b_at) check("anim_with_frame", b_ft, 1);
                if (b_pe) begin
                    if (last_pe >= 0) check("pix_en_period", cyc - last_pe, 4);
                    last_pe = cyc;
                    if (sb_q.size() != 0) begin
                        exp       = sb_q.pop_front();
                        got.h     = b_h;
                        got.v     = b_v;
                        got.valid = b_valid;
                        got.hs    = b_hs;
                        got.vs    = b_vs;
                        got.ft    = b_ft;
                        got.at    = b_at;
                        checks++;
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL sb_pixel: got h=%0d v=%0d valid=%b hs=%b vs=%b ft=%b at=%b, expected h=%0d v=%0d valid=%b hs=%b vs=%b ft=%b at=%b",
                                     got.h, got.v, got.valid, got.hs, got.vs, got.ft, got.at,
                                     exp.h, exp.v, exp.valid, exp.hs, exp.vs, exp.ft, exp.at);
                        end
                    end
                end
            end
        end
    endtask

    task automatic frame_monitor();
        int last_ft;
        last_ft = -1;
        forever begin
            @(negedge clk);
            if (!space_en) begin
                last_ft = -1;
            end else if (b_ft) begin
                if (last_ft >= 0) check("frame_spacing", cyc - last_ft, 1344);
                last_ft = cyc;
            end
        end
    endtask

    task automatic vs_monitor();
        logic prev_vs;
        int   start;
        prev_vs = 1'b1;
        start   = 0;
        forever begin
            @(negedge clk);
            if (!vs_en) begin
                prev_vs = 1'b1;
            end else begin
                if (prev_vs && !b_vs) begin
                    check("vsync_start_v", b_v, 10);
                    check("vsync_start_h", b_h, 0);
                    start = cyc;
                end else if (!prev_vs && b_vs) begin
                    check("vsync_len", cyc - start, 192);
                end
                prev_vs = b_vs;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        int   hs_low, val_hi, hs_first_h, hs_end_h, prev_h, prev_v, prev_hs;
        int   c_low, c_zero0, c_zero1, n;
        errors = 0; checks = 0;
        sb_en = 0; space_en = 0; vs_en = 0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        fork
            sb_monitor();
            frame_monitor();
            vs_monitor();
        join_none

        repeat (3) @(negedge clk);
        check("rst_h", a_h, 799);
        check("rst_v", a_v, 524);
        check("rst_hsync", a_hs, 1);
        check("rst_vsync", a_vs, 1);
        check("rst_valid", a_valid, 0);
        check("rst_pix_en", a_pe, 0);
        check("rst_frame_tick", a_ft, 0);
        check("rst_anim_tick", a_at, 0);
        check("rst_small_h", b_h, 23);
        check("rst_small_v", b_v, 13);
        check("rst_div1_pix_en", c_pe, 0);

        push_frames(13);
        sb_en = 1; space_en = 1; vs_en = 1;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("start_pix_en", a_pe, (k == 4));
            if (k == 1) begin
                check("div1_first_pix_en", c_pe, 1);
                check("div1_first_h", c_h, 0);
            end
        end
        check("start_h", a_h, 0);
        check("start_v", a_v, 0);
        check("start_valid", a_valid, 1);

        // One full default line, plus the PIX_DIV=1 build alongside it.
        hs_low = 0; val_hi = 0; hs_first_h = -1; hs_end_h = -1;
        prev_h = 0; prev_v = 0; prev_hs = 1;
        c_low = 0; c_zero0 = -1; c_zero1 = -1;
        for (int t = 0; t < 3200; t++) begin
            if (t > 0) @(negedge clk);
            if (!a_hs) begin
                hs_low++;
                if (hs_first_h < 0) hs_first_h = int'(a_h);
            end
            if (prev_hs == 0 && a_hs && hs_end_h < 0) hs_end_h = int'(a_h);
            if (a_valid) val_hi++;
            if (!c_pe) c_low++;
            if (c_h == 10'd0) begin
                if (c_zero0 < 0) c_zero0 = cyc;
                else if (c_zero1 < 0) c_zero1 = cyc;
            end
            prev_h = int'(a_h); prev_v = int'(a_v); prev_hs = int'(a_hs);
        end
        @(negedge clk);
        check("hsync_low_clk", hs_low, 384);
        check("hsync_start_h", hs_first_h, 656);
        check("hsync_end_h", hs_end_h, 752);
        check("valid_high_clk", val_hi, 2560);
        check("wrap_prev_h", prev_h, 799);
        check("wrap_prev_v", prev_v, 0);
        check("wrap_h", a_h, 0);
        check("wrap_v", a_v, 1);
        check("div1_pix_en_low", c_low, 0);
        check("div1_line_clk", c_zero1 - c_zero0, 800);

        wait_drain(25000);
        sb_en = 0; space_en = 0; vs_en = 0;

        // Mid-line reset on the small raster.
        n = 0;
        while (!(b_h == 10'd10 && b_v == 10'd5) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("midreset_reached", (b_h == 10'd10 && b_v == 10'd5), 1);
        #1 rst_b = 1'b0;
        #1;
        check("mid_rst_h", b_h, 23);
        check("mid_rst_v", b_v, 13);
        check("mid_rst_hsync", b_hs, 1);
        check("mid_rst_vsync", b_vs, 1);
        check("mid_rst_valid", b_valid, 0);
        check("mid_rst_pix_en", b_pe, 0);
        check("mid_rst_frame_tick", b_ft, 0);
        check("mid_rst_anim_tick", b_at, 0);
        repeat (2) @(negedge clk);
        sb_q.delete();
        push_frames(7);
        sb_en = 1; space_en = 1;
        rst_b = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("restart_pix_en", b_pe, (k == 4));
        end
        check("restart_h", b_h, 0);
        check("restart_v", b_v, 0);
        check("restart_valid", b_valid, 1);
        wait_drain(12000);
        sb_en = 0; space_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
